// File: rtl/mul_result_accum.sv
// mul_result_accum: consumer end of the multiplier array. Delays the
// operand-issue acceptance flag so it lines up with the product lanes, sums
// all lanes of each flagged beat, accumulates a burst of len beats and
// presents the result on a valid/ready port.
module mul_result_accum #(
  parameter int NUM_LANES = 32,
  parameter int PROD_W    = 32,
  parameter int ACC_W     = 48,
  parameter int MUL_LAT   = 3,
  parameter int LEN_W     = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [LEN_W-1:0]            len_i,
  input  logic                        in_valid_i,
  input  logic [NUM_LANES*PROD_W-1:0] mul_p_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [ACC_W-1:0]            out_sum_o,
  output logic                        busy_o,
  output logic                        overflow_o,
  output logic                        err_o
);

  // Lane sum carries log2(NUM_LANES) extra bits so it can never wrap.
  localparam int SUM_W = PROD_W + $clog2(NUM_LANES);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                           state, state_nxt;
  logic [LEN_W-1:0]                 len_q, issued_cnt, rcvd_cnt;
  logic [MUL_LAT:1]                 vld_pipe;
  logic [NUM_LANES-1:0][PROD_W-1:0] lanes;
  logic [SUM_W-1:0]                 lane_sum_c, lane_sum;
  logic                             sum_vld;
  logic [ACC_W-1:0]                 acc;
  logic [ACC_W:0]                   acc_add;
  logic                             start_acc, accept, add_en, last_add;

  assign lanes     = mul_p_i;
  assign start_acc = (state == IDLE) && start_i;
  assign accept    = in_valid_i && (state == ACCUM) && (issued_cnt < len_q);
  assign add_en    = sum_vld && (state == ACCUM);
  // rcvd_cnt < len_q whenever add_en is set, so the +1 cannot wrap.
  assign last_add  = add_en && ((rcvd_cnt + LEN_W'(1)) == len_q);
  assign acc_add   = {1'b0, acc} + {1'b0, ACC_W'(lane_sum)};

  assign out_valid_o = (state == HOLD);
  assign busy_o      = (state != IDLE);
  assign out_sum_o   = acc;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: leave ACCUM on the same edge the final beat is added, so the
  // result is visible MUL_LAT+2 cycles after the last issue.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (len_i == '0) ? HOLD : ACCUM;
      ACCUM:   if (last_add) state_nxt = HOLD;
      HOLD:    if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst length and issue/receive beat counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q      <= '0;
      issued_cnt <= '0;
      rcvd_cnt   <= '0;
    end else if (start_acc) begin
      len_q      <= len_i;
      issued_cnt <= '0;
      rcvd_cnt   <= '0;
    end else begin
      if (accept) issued_cnt <= issued_cnt + LEN_W'(1);
      if (add_en) rcvd_cnt   <= rcvd_cnt + LEN_W'(1);
    end
  end

  // Acceptance delay line; its tail is high in the cycle the products arrive.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= accept;
      for (int i = 2; i <= MUL_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Zero-extended sum across all product lanes.
  always_comb begin
    lane_sum_c = '0;
    for (int k = 0; k < NUM_LANES; k++) lane_sum_c = lane_sum_c + SUM_W'(lanes[k]);
  end

  // Lane-sum register, loaded only on flagged beats.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_sum <= '0;
      sum_vld  <= 1'b0;
    end else begin
      sum_vld <= vld_pipe[MUL_LAT];
      if (vld_pipe[MUL_LAT]) lane_sum <= lane_sum_c;
    end
  end

  // Accumulator: cleared by an accepted start, wraps modulo 2^ACC_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)          acc <= '0;
    else if (start_acc) acc <= '0;
    else if (add_en)    acc <= acc_add[ACC_W-1:0];
  end

  // Sticky overflow and protocol-error flags, cleared by an accepted start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o <= 1'b0;
      err_o      <= 1'b0;
    end else if (start_acc) begin
      overflow_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (add_en && acc_add[ACC_W]) overflow_o <= 1'b1;
      if (in_valid_i && !accept)    err_o      <= 1'b1;
    end
  end

endmodule

// File: doc/mul_result_accum.md
Name: mul_result_accum

Overview:
- Consumer end of the multiplier array: takes the NUM_LANES product lanes (32-bit, unsigned) on the array's clock.
- Aligns the products with the operand-issue valid strobe, sums all lanes per beat, and accumulates a burst of len_i beats into one ACC_W result.
- Presents the result on a valid/ready output port.
- Sits directly downstream of the multiplier array in the dot-product datapath. The issue-side valid is the same strobe the operand feeder uses when it drives the array.

Parameters:
- NUM_LANES, 32, number of product lanes on mul_p_i; must be a power of 2, at least 2.
- PROD_W, 32, width of each product lane.
- ACC_W, 48, accumulator and result width.
- MUL_LAT, 3, multiplier array latency in cycles, from operands to mul_p valid; at least 1.
- LEN_W, 16, width of the burst length.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle pulse; begins a burst, sampled only in IDLE.
- len_i  in  LEN_W  number of beats in the burst; latched on an accepted start_i.
- in_valid_i  in  1  operands were presented to the array this cycle; same cycle as issue.
- mul_p_i  in  NUM_LANES*PROD_W  product lanes; lane k is bits [PROD_W*k+PROD_W-1 : PROD_W*k].
- out_valid_o  out  1  result available.
- out_ready_i  in  1  downstream accepts the result.
- out_sum_o  out  ACC_W  accumulated result.
- busy_o  out  1  burst in progress or result not yet taken.
- overflow_o  out  1  sticky; accumulator carried out of ACC_W during the current burst.
- err_o  out  1  sticky; in_valid_i was seen while no beat could be accepted.

Behaviour:
- Reset state, asynchronous: state = IDLE. All counters, the delay line, the lane-sum register and the accumulator are 0. Outputs out_valid_o, busy_o, overflow_o and err_o are 0, and out_sum_o = 0.
- States:
  - IDLE to ACCUM on start_i when len_i != 0.
  - IDLE to HOLD on start_i when len_i == 0; accumulator = 0.
  - ACCUM to HOLD in the cycle after the final aligned beat is added.
  - HOLD to IDLE on out_valid_o && out_ready_i.
- Beat acceptance:
  - A beat is accepted when in_valid_i = 1, state is ACCUM, and issued_cnt < len.
  - issued_cnt increments on each accepted beat.
  - The acceptance flag is delayed MUL_LAT cycles so it lines up with mul_p_i.
- Error flag:
  - in_valid_i in IDLE or HOLD, or in ACCUM with issued_cnt == len, is not accepted and sets err_o.
  - err_o and overflow_o clear only on an accepted start_i.
- Pipeline timing, with a beat accepted at cycle T:
  - At T+MUL_LAT, if the delayed flag is set, the lane-sum register captures the zero-extended sum of all NUM_LANES lanes. This sum is PROD_W+log2(NUM_LANES) bits.
  - At T+MUL_LAT+1, the accumulator adds the lane sum, zero-extended or truncated to ACC_W, and rcvd_cnt increments.
  - Accumulation wraps modulo 2^ACC_W. A carry out of the accumulator sets overflow_o.
- Result timing:
  - When rcvd_cnt reaches len, state enters HOLD at T_last+MUL_LAT+2, with out_valid_o = 1 and out_sum_o = accumulator.
  - Latency from the last accepted in_valid_i to out_valid_o is MUL_LAT+2 cycles.
- Hold behaviour:
  - out_sum_o and out_valid_o stay stable in HOLD until the handshake completes.
  - out_sum_o keeps its last value in IDLE.
  - Back-to-back operation: the handshake cycle returns to IDLE; start_i is honoured from the next cycle.
- busy_o = 1 in ACCUM and HOLD.
- start_i outside IDLE is ignored, and has no effect on the flags.
- Accumulator clears on an accepted start_i; a new burst never includes stale data.
- Reset asserted mid-burst returns everything to the reset state immediately. Products still in flight are discarded, because the delay-line flags are cleared.
- Gapped in_valid_i is legal; only flagged beats are summed.
- mul_p_i values on unflagged cycles are ignored.

Test Plan:
- Reset then idle: after reset deassert, all outputs are 0. Pulse in_valid_i once in IDLE -> err_o = 1, out_valid_o stays 0.
- Single beat: start_i with len = 1, then in_valid_i one cycle with every lane = 1 at T+MUL_LAT -> out_valid_o at T+5 with MUL_LAT = 3, out_sum_o = 32.
- Burst of 4 with gaps: in_valid_i at cycles 0, 1, 3, 6; lane k = k+1 on beat j = 1..4, scaled by j -> out_sum_o = 528*10 = 5280. err_o stays 0.
- Back-pressure and back-to-back: hold out_ready_i = 0 for 5 cycles -> out_valid_o and out_sum_o stay stable. Handshake, then start_i with len = 0 on the next cycle -> result 0 one cycle later.
- Overflow: ACC_W = 37, 2 beats with all lanes = 0xFFFFFFFF -> out_sum_o = (2*32*(2^32-1)) mod 2^37 and overflow_o = 1. A new start_i clears the flag.
- Reset mid-burst plus extra beats:
  - Assert rst_i after 2 of 4 beats -> immediate IDLE; the next burst of len = 1 with lanes = 2 gives 64.
  - A 5th in_valid_i in a len = 4 burst -> err_o = 1 and the sum excludes it.
